// File: rtl/fp_round_pack.sv
`default_nettype none
// ============================================================================
// Module   : fp_round_pack
// Brief    : Two-stage round-to-nearest-even, range check and IEEE-style pack
//            with valid/ready flow control and sticky exception flags.
// Revision : 1.0  initial release
// ============================================================================
module fp_round_pack #(
  parameter int N = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [N/4-1:0]   in_exp,
  input  logic [N-N/4-1:0] in_mag,
  input  logic [2:0]       in_grs,
  input  logic             in_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic [2:0]       out_flags,
  input  logic             flag_clr,
  output logic [2:0]       flags_sticky
);

  localparam int c_E = N / 4;
  localparam int c_M = N - N / 4;
  localparam int c_F = c_M - 1;

  // Flow control
  logic w_s2_adv;
  logic w_s1_adv;
  logic w_out_xfer;

  // Stage 1 (rounding) signals
  logic         w_inc;
  logic [c_M:0] w_rnd;
  logic         w_unf_in;

  logic         r_s1_v;
  logic         r_s1_sign;
  logic [c_E-1:0] r_s1_exp;
  logic [c_M:0] r_s1_rnd;
  logic         r_s1_inx;
  logic         r_s1_zero;
  logic         r_s1_unf;

  // Stage 2 (renormalize / pack) signals
  logic           w_carry;
  logic [c_E:0]   w_exp_f;
  logic [c_F-1:0] w_frac;
  logic           w_ovf;
  logic [N-1:0]   w_sum;
  logic [2:0]     w_flags;

  logic         r_s2_v;
  logic [N-1:0] r_out_sum;
  logic [2:0]   r_out_flags;
  logic [2:0]   r_sticky;

  assign w_s2_adv   = !r_s2_v || out_ready;
  assign w_s1_adv   = !r_s1_v || w_s2_adv;
  assign in_ready   = !rst && w_s1_adv;
  assign w_out_xfer = r_s2_v && out_ready;

  assign w_inc    = in_grs[2] & (in_grs[1] | in_grs[0] | in_mag[0]);
  assign w_rnd    = {1'b0, in_mag} + {{c_M{1'b0}}, w_inc};
  assign w_unf_in = !in_zero && (in_exp == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v    <= 1'b0;
      r_s1_sign <= 1'b0;
      r_s1_exp  <= '0;
      r_s1_rnd  <= '0;
      r_s1_inx  <= 1'b0;
      r_s1_zero <= 1'b0;
      r_s1_unf  <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_v <= in_valid;
      if (in_valid) begin
        r_s1_sign <= in_sign;
        r_s1_exp  <= in_exp;
        r_s1_rnd  <= w_rnd;
        r_s1_inx  <= |in_grs;
        r_s1_zero <= in_zero;
        r_s1_unf  <= w_unf_in;
      end
    end
  end

  // Carry-out of the rounded significand means it became exactly 2.0.
  assign w_carry = r_s1_rnd[c_M];
  assign w_exp_f = {1'b0, r_s1_exp} + {{c_E{1'b0}}, w_carry};
  assign w_frac  = w_carry ? r_s1_rnd[c_M-1:1] : r_s1_rnd[c_F-1:0];
  assign w_ovf   = (w_exp_f >= {1'b0, {c_E{1'b1}}});

  always_comb begin
    w_sum   = '0;
    w_flags = 3'b000;
    if (r_s1_zero) begin
      w_sum = {r_s1_sign, {(N-1){1'b0}}};
    end else if (r_s1_unf) begin
      w_sum   = {r_s1_sign, {(N-1){1'b0}}};
      w_flags = 3'b011;
    end else if (w_ovf) begin
      w_sum   = {r_s1_sign, {c_E{1'b1}}, {c_F{1'b0}}};
      w_flags = 3'b101;
    end else begin
      w_sum   = {r_s1_sign, w_exp_f[c_E-1:0], w_frac};
      w_flags = {2'b00, r_s1_inx};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_v      <= 1'b0;
      r_out_sum   <= '0;
      r_out_flags <= 3'b000;
    end else if (w_s2_adv) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_out_sum   <= w_sum;
        r_out_flags <= w_flags;
      end
    end
  end

  // A clear coinciding with a transfer keeps only that transfer's flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky <= 3'b000;
    end else if (w_out_xfer && flag_clr) begin
      r_sticky <= r_out_flags;
    end else if (flag_clr) begin
      r_sticky <= 3'b000;
    end else if (w_out_xfer) begin
      r_sticky <= r_sticky | r_out_flags;
    end
  end

  assign out_valid    = r_s2_v;
  assign out_sum      = r_out_sum;
  assign out_flags    = r_out_flags;
  assign flags_sticky = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_fp_round_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_round_pack
// Brief    : Directed self-checking bench for fp_round_pack (N=32).
// Revision : 1.0  initial release
// ============================================================================
module tb_fp_round_pack;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [23:0] in_mag;
  logic [2:0]  in_grs;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic [2:0]  out_flags;
  logic        flag_clr;
  logic [2:0]  flags_sticky;

  int n_pass  = 0;
  int n_total = 0;

  fp_round_pack #(.N(32)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_mag       (in_mag),
    .in_grs       (in_grs),
    .in_zero      (in_zero),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_flags    (out_flags),
    .flag_clr     (flag_clr),
    .flags_sticky (flags_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entered #1 after a rising edge. Presents one input, reports the edge
  // count from acceptance to out_valid (-1 on timeout), then lets the
  // output transfer and returns #1 after that edge.
  task automatic run_vec(input logic s, input logic [7:0] e, input logic [23:0] m,
                         input logic [2:0] g, input logic z,
                         output logic [31:0] sum, output logic [2:0] fl, output int lat);
    out_ready = 1'b1;
    in_sign = s; in_exp = e; in_mag = m; in_grs = g; in_zero = z;
    in_valid = 1'b1;
    lat = -1; sum = '0; fl = '0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 2; k <= 10; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k; sum = out_sum; fl = out_flags;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b expected 0", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_total++; if (out_sum !== 32'h0) $display("FAIL rst_out_sum: got %h expected 00000000", out_sum); else n_pass++;
    n_total++; if (out_flags !== 3'b000) $display("FAIL rst_out_flags: got %b expected 000", out_flags); else n_pass++;
    n_total++; if (flags_sticky !== 3'b000) $display("FAIL rst_sticky: got %b expected 000", flags_sticky); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b expected 1", in_ready); else n_pass++;
  endtask

  task automatic test_round();
    logic        s_t [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0]  e_t [8] = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h55, 8'hFF, 8'h7F};
    logic [23:0] m_t [8] = '{24'h800000, 24'h800000, 24'h800001, 24'hFFFFFF,
                             24'hC00000, 24'h123456, 24'h800000, 24'h800001};
    logic [2:0]  g_t [8] = '{3'b000, 3'b100, 3'b100, 3'b110, 3'b011, 3'b111, 3'b000, 3'b101};
    logic        z_t [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] x_t [8] = '{32'h3F800000, 32'h3F800000, 32'h3F800002, 32'h40000000,
                             32'h3FC00000, 32'h80000000, 32'h7F800000, 32'hBF800002};
    logic [2:0]  f_t [8] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b101, 3'b001};
    logic [31:0] sum;
    logic [2:0]  fl;
    int          lat;
    for (int i = 0; i < 8; i++) begin
      run_vec(s_t[i], e_t[i], m_t[i], g_t[i], z_t[i], sum, fl, lat);
      n_total++; if (lat != 2) $display("FAIL round[%0d]_latency: got %0d expected 2", i, lat); else n_pass++;
      n_total++; if (sum !== x_t[i]) $display("FAIL round[%0d]_sum: got %h expected %h", i, sum, x_t[i]); else n_pass++;
      n_total++; if (fl !== f_t[i]) $display("FAIL round[%0d]_flags: got %b expected %b", i, fl, f_t[i]); else n_pass++;
    end
  endtask

  task automatic test_range_and_sticky();
    logic [31:0] sum;
    logic [2:0]  fl;
    int          lat;
    run_vec(1'b1, 8'hFE, 24'hFFFFFF, 3'b100, 1'b0, sum, fl, lat);
    n_total++; if (sum !== 32'hFF800000) $display("FAIL ovf_sum: got %h expected FF800000", sum); else n_pass++;
    n_total++; if (fl !== 3'b101) $display("FAIL ovf_flags: got %b expected 101", fl); else n_pass++;
    run_vec(1'b0, 8'h00, 24'h800000, 3'b000, 1'b0, sum, fl, lat);
    n_total++; if (sum !== 32'h00000000) $display("FAIL unf_sum: got %h expected 00000000", sum); else n_pass++;
    n_total++; if (fl !== 3'b011) $display("FAIL unf_flags: got %b expected 011", fl); else n_pass++;
    n_total++; if (flags_sticky !== 3'b111) $display("FAIL sticky_accum: got %b expected 111", flags_sticky); else n_pass++;
    flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    n_total++; if (flags_sticky !== 3'b000) $display("FAIL sticky_clear: got %b expected 000", flags_sticky); else n_pass++;
    run_vec(1'b1, 8'h00, 24'h900000, 3'b000, 1'b0, sum, fl, lat);
    n_total++; if (sum !== 32'h80000000) $display("FAIL unf_neg_sum: got %h expected 80000000", sum); else n_pass++;
    n_total++; if (flags_sticky !== 3'b011) $display("FAIL sticky_after_unf: got %b expected 011", flags_sticky); else n_pass++;
    // Clear and transfer in the same cycle: only the new flags survive.
    out_ready = 1'b0;
    in_sign = 1'b0; in_exp = 8'h7F; in_mag = 24'h800000; in_grs = 3'b100; in_zero = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) break;
      @(posedge clk); #1;
    end
    n_total++; if (out_valid !== 1'b1) $display("FAIL clr_xfer_wait: got out_valid %b expected 1", out_valid); else n_pass++;
    flag_clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    n_total++; if (flags_sticky !== 3'b001) $display("FAIL sticky_clr_with_xfer: got %b expected 001", flags_sticky); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic        s_t [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0]  e_t [4] = '{8'h7F, 8'h7F, 8'h80, 8'h7F};
    logic [23:0] m_t [4] = '{24'h800000, 24'h800001, 24'h800000, 24'h800000};
    logic [31:0] x_t [4] = '{32'h3F800000, 32'h3F800001, 32'h40000000, 32'hBF800000};
    int   idx = 0;
    int   got = 0;
    logic acc;
    logic xfer;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin
        in_sign = s_t[idx]; in_exp = e_t[idx]; in_mag = m_t[idx]; in_grs = 3'b000; in_zero = 1'b0;
      end
      @(negedge clk);
      if (cyc == 2) begin
        n_total++; if (in_ready !== 1'b0) $display("FAIL b2b_third_ready: got %b expected 0", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b1) $display("FAIL b2b_out_valid: got %b expected 1", out_valid); else n_pass++;
      end
      if (cyc == 5) begin
        n_total++; if (out_sum !== x_t[0]) $display("FAIL b2b_hold_sum: got %h expected %h", out_sum, x_t[0]); else n_pass++;
        n_total++; if (idx !== 2) $display("FAIL b2b_accepted_while_stalled: got %0d expected 2", idx); else n_pass++;
      end
      acc  = in_valid & in_ready;
      xfer = out_valid & out_ready;
      if (xfer) begin
        n_total++;
        if (got >= 4) $display("FAIL b2b_extra_output: got %h expected none", out_sum);
        else if (out_sum !== x_t[got]) $display("FAIL b2b_order[%0d]: got %h expected %h", got, out_sum, x_t[got]);
        else n_pass++;
        got++;
      end
      @(posedge clk); #1;
      if (acc) idx++;
      if (cyc == 5) out_ready = 1'b1;
      if (got == 4 && idx == 4) break;
    end
    in_valid = 1'b0;
    n_total++; if (got != 4) $display("FAIL b2b_count: got %0d expected 4", got); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_drained: got %b expected 0", out_valid); else n_pass++;
  endtask

  task automatic test_reset_flush();
    logic [31:0] sum;
    logic [2:0]  fl;
    int          lat;
    out_ready = 1'b0;
    in_sign = 1'b0; in_exp = 8'h7F; in_mag = 24'h800000; in_grs = 3'b100; in_zero = 1'b0;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_total++; if (out_valid !== 1'b1) $display("FAIL flush_pre_valid: got %b expected 1", out_valid); else n_pass++;
    n_total++; if (flags_sticky !== 3'b001) $display("FAIL flush_pre_sticky: got %b expected 001", flags_sticky); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_total++; if (flags_sticky !== 3'b000) $display("FAIL flush_sticky: got %b expected 000", flags_sticky); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL flush_ready_in_rst: got %b expected 0", in_ready); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL flush_ready_after: got %b expected 1", in_ready); else n_pass++;
    run_vec(1'b0, 8'h80, 24'hC00000, 3'b000, 1'b0, sum, fl, lat);
    n_total++; if (lat != 2) $display("FAIL flush_latency: got %0d expected 2", lat); else n_pass++;
    n_total++; if (sum !== 32'h40400000) $display("FAIL flush_sum: got %h expected 40400000", sum); else n_pass++;
    n_total++; if (fl !== 3'b000) $display("FAIL flush_flags: got %b expected 000", fl); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mag = '0;
    in_grs = '0; in_zero = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
    test_reset();
    test_round();
    test_range_and_sticky();
    test_back_to_back();
    test_reset_flush();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp_round_pack.md
FP_ROUND_PACK -- requirements
Module: fp_round_pack

Interface
REQ-001 Parameter N, default 32: total float width; exponent width E=N/4, significand width M=N-N/4 (hidden bit at MSB), fraction width M-1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream normalizer result valid.
REQ-005 in_ready  output  1  block accepts input this cycle.
REQ-006 in_sign  input  1  result sign.
REQ-007 in_exp  input  E  biased exponent of the normalized significand.
REQ-008 in_mag  input  M  normalized significand, MSB=1 unless in_zero.
REQ-009 in_grs  input  3  guard, round, sticky bits below in_mag LSB, in that order.
REQ-010 in_zero  input  1  exact-zero result; in_mag and in_exp are ignored.
REQ-011 out_valid  output  1  out_sum valid.
REQ-012 out_ready  input  1  downstream accepts out_sum.
REQ-013 out_sum  output  N  packed IEEE-style result {sign, exp, fraction}.
REQ-014 out_flags  output  3  {ovf, unf, inexact} for the current out_sum.
REQ-015 flag_clr  input  1  clears the sticky flags.
REQ-016 flags_sticky  output  3  OR-accumulated {ovf, unf, inexact} over all transferred results.

Function
REQ-017 Two-stage pipeline: S1 computes the round increment; S2 renormalizes, checks range, and packs. Latency is exactly 2 cycles from the in_valid&in_ready transfer to out_valid when the pipeline is not stalled.
REQ-018 Transfers occur only when valid&ready are both high; out_sum and out_flags stay stable while out_valid=1 and out_ready=0.
REQ-019 S2 advances when it is empty or out_ready=1; S1 advances when it is empty or S2 advances; in_ready = S1 empty or S1 advances; all three conditions are combinational, with no bubble on a full-throughput stream.
REQ-020 Rounding is round-to-nearest-even: increment = G & (R | S | mag[0]).
REQ-021 The rounded significand is computed at M+1 bits; on carry-out, shift right 1 and exp+1.
REQ-022 Overflow: when the final exp equals all ones (including input exp all ones), output sign, exp all ones, fraction 0, ovf=1, inexact=1.
REQ-023 Underflow: when in_exp=0 and in_zero=0, output signed zero with unf=1 and inexact=1, regardless of rounding.
REQ-024 in_zero=1: output {in_sign, 0...0} with all flags 0.
REQ-025 inexact = G|R|S for normal results; otherwise inexact is set per REQ-022 and REQ-023.
REQ-026 Fraction packed = rounded significand[M-2:0]; the hidden bit is dropped.
REQ-027 flags_sticky |= out_flags on each output transfer; flag_clr clears it. When flag_clr coincides with a transfer, the register takes exactly that transfer's flags (the set wins).

Reset
REQ-028 With rst=1 at a clock edge: both stage valids=0, out_valid=0, out_sum=0, out_flags=0, flags_sticky=0; in-flight results are discarded.
REQ-029 While rst=1, in_ready=0; in_ready=1 on the first cycle after reset deasserts.

Verification
REQ-030 exp=8'h7F, mag=24'h800000, grs=000, sign=0 -> two cycles later out_sum=32'h3F800000, flags=000.
REQ-031 Tie to even, exp=8'h7F, mag=24'h800000, grs=100 -> out_sum=32'h3F800000, flags=001; with mag=24'h800001, grs=100 -> 32'h3F800002, flags=001.
REQ-032 Carry renormalize, exp=8'h7F, mag=24'hFFFFFF, grs=110 -> out_sum=32'h40000000, flags=001.
REQ-033 Overflow, exp=8'hFE, mag=24'hFFFFFF, grs=100, sign=1 -> out_sum=32'hFF800000, flags=101; underflow, exp=0, mag=24'h800000 -> 32'h00000000, flags=011; flags_sticky=111 afterwards; flag_clr -> 000.
REQ-034 Backpressure: four back-to-back inputs with out_ready=0 -> two held, in_ready=0 from the third; out_ready=1 delivers all four in order with none lost or duplicated.
REQ-035 rst asserted with both stages valid and out_ready=0 -> next cycle out_valid=0, flags_sticky=0; the first input after reset emerges 2 cycles after acceptance.
